// File: rtl/alu_issuer.sv
// alu_issuer: 4-stage (IDLE/DECODE/EXEC/WB) MIPS R-type issuer driving an external ALU, with 32x32 register file.
// Optional ALU_ISSUER_ZCOUNT_EN adds a saturating 16-bit count of completions with zero result.
module alu_issuer #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [31:0] X,
   output logic [31:0] Y,
   output logic [3:0]  S,
   input  logic [31:0] r,
   input  logic        Zflag,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        done,
   output logic        illegal,
   output logic        zero
`ifdef ALU_ISSUER_ZCOUNT_EN
   ,
   output logic [15:0] zcount
`endif
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   state_t      state, state_nx;
   logic [4:0]  rs_q, rt_q, rd_q;
   logic [5:0]  funct_q;
   logic [31:0] res_q;
   logic        zf_q;
   logic        legal;
   logic [3:0]  s_dec;
   logic [31:0] regs [NREG];

   // shamt and opcode fields play no part in R-type ALU issue
   logic unused_instr;
   assign unused_instr = ^{instr[31:26], instr[10:6]};

   assign instr_ready = (state == IDLE);
   assign rd_data     = regs[rd_addr];

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      legal = 1'b1;
      s_dec = 4'd0;
      case (funct_q)
         6'h24:   s_dec = 4'd0;
         6'h25:   s_dec = 4'd1;
         6'h20:   s_dec = 4'd2;
         6'h22:   s_dec = 4'd6;
         6'h2A:   s_dec = 4'd7;
         6'h27:   s_dec = 4'd12;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (instr_valid) state_nx = DECODE;
         DECODE:  state_nx = legal ? EXEC : IDLE;
         EXEC:    state_nx = WB;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         funct_q <= '0;
         X       <= '0;
         Y       <= '0;
         S       <= '0;
         res_q   <= '0;
         zf_q    <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         zero    <= 1'b0;
      end else begin
         state   <= state_nx;
         done    <= (state == WB);
         illegal <= (state == DECODE) && !legal;
         if (state == IDLE && instr_valid) begin
            rs_q    <= instr[25:21];
            rt_q    <= instr[20:16];
            rd_q    <= instr[15:11];
            funct_q <= instr[5:0];
         end
         // operands are sampled here, so later host writes to rs/rt cannot reach this instruction
         if (state == DECODE && legal) begin
            X <= regs[rs_q];
            Y <= regs[rt_q];
            S <= s_dec;
         end
         if (state == EXEC) begin
            res_q <= r;
            zf_q  <= Zflag;
         end
         if (state == WB) zero <= zf_q;
      end
   end

   // NOTE: the register file is reset explicitly because software expects all registers to read 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
         // later assignment wins, giving write-back priority over a same-address host write
         if (state == WB && rd_q != 5'd0) regs[rd_q] <= res_q;
      end
   end

`ifdef ALU_ISSUER_ZCOUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zcount <= '0;
      end else if (state == WB && zf_q && zcount != 16'hFFFF) begin
         zcount <= zcount + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: behavioural ALU, register model and a scoreboard queue of expected write-backs.
module tb_alu_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] X, Y;
   logic [3:0]  S;
   logic [31:0] r;
   logic        Zflag;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        done, illegal, zero;
`ifdef ALU_ISSUER_ZCOUNT_EN
   logic [15:0] zcount;
`endif

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
      logic        z;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] mreg [32];
   int          zc_exp = 0;
   logic [31:0] last_x = '0, last_y = '0;
   logic [3:0]  last_s = '0;

   always #5 clk = ~clk;

   alu_issuer #(.NREG(32)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .X(X), .Y(Y), .S(S), .r(r), .Zflag(Zflag),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .done(done), .illegal(illegal), .zero(zero)
`ifdef ALU_ISSUER_ZCOUNT_EN
      , .zcount(zcount)
`endif
   );

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
      case (s)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return {31'd0, ($signed(a) < $signed(b))};
         4'd12:   return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [3:0] s_of(input logic [5:0] f);
      case (f)
         6'h24:   return 4'd0;
         6'h25:   return 4'd1;
         6'h20:   return 4'd2;
         6'h22:   return 4'd6;
         6'h2A:   return 4'd7;
         6'h27:   return 4'd12;
         default: return 4'hF;
      endcase
   endfunction

   assign r     = alu_ref(X, Y, S);
   assign Zflag = (r == 32'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      if (a != 5'd0) mreg[a] = d;
   endtask

   task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
      rd_addr = a;
      #1;
      check(tag, rd_data, exp);
   endtask

   // legal instruction: checks issue timing, operands, then pops the scoreboard on done
   task automatic run_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [5:0] funct, input bit hold_valid, input bit conflict);
      logic [3:0]  s;
      logic [31:0] x, y;
      exp_t        e;
      int          lat;
      bit          seen;
      s = s_of(funct); x = mreg[rs]; y = mreg[rt];
      @(negedge clk);
      check("ready_idle", instr_ready, 1);
      instr = {6'd0, rs, rt, rd, 5'd0, funct};
      instr_valid = 1'b1;
      e.rd = rd; e.val = alu_ref(x, y, s); e.z = (e.val == 32'd0);
      sb.push_back(e);
      seen = 1'b0; lat = 0;
      for (int k = 1; k <= 8 && !seen; k++) begin
         @(negedge clk);
         if (!hold_valid || k >= 4) instr_valid = 1'b0;
         if (k <= 3) check("ready_busy", instr_ready, 0);
         if (k == 2 || k == 3) begin
            check("exec_x", X, x);
            check("exec_y", Y, y);
            check("exec_s", S, s);
         end
         if (conflict && k == 3) begin
            wr_en = 1'b1; wr_addr = rd; wr_data = 32'h0000AAAA;
         end
         if (k == 4) wr_en = 1'b0;
         if (done) begin seen = 1'b1; lat = k; end
      end
      wr_en = 1'b0; instr_valid = 1'b0;
      check("done_latency", lat, 4);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         peek("wb_data", e.rd, (e.rd == 5'd0) ? 32'd0 : e.val);
         check("zero_flag", zero, e.z);
         if (e.rd != 5'd0) mreg[e.rd] = e.val;
         if (e.z) zc_exp++;
`ifdef ALU_ISSUER_ZCOUNT_EN
         check("zcount", zcount, zc_exp);
`endif
      end
      last_x = x; last_y = y; last_s = s;
      @(negedge clk);
      check("done_pulse", done, 0);
      check("zero_hold", zero, e.z);
   endtask

   task automatic run_illegal(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [5:0] funct);
      @(negedge clk);
      instr = {6'd0, rs, rt, rd, 5'd0, funct};
      instr_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         instr_valid = 1'b0;
         check("ill_done", done, 0);
         check("ill_pulse", illegal, (k == 2) ? 1 : 0);
         if (k == 2) begin
            check("ill_ready", instr_ready, 1);
            check("ill_x", X, last_x);
            check("ill_y", Y, last_y);
            check("ill_s", S, last_s);
         end
      end
      peek("ill_rd_kept", rd, mreg[rd]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      #1;
      check("rst_x", X, 0);
      check("rst_s", S, 0);
      check("rst_done", done, 0);
      check("rst_illegal", illegal, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", instr_ready, 1);
      check("rst_zero", zero, 0);

      // ADD
      host_write(5'd1, 32'd5);
      host_write(5'd2, 32'd7);
      peek("preload_r1", 5'd1, 32'd5);
      host_write(5'd0, 32'hDEAD);
      peek("r0_hardwired", 5'd0, 32'd0);
      run_op(5'd1, 5'd2, 5'd3, 6'h20, 1'b0, 1'b0);
      peek("add_r3", 5'd3, 32'd12);
      check("add_zero", zero, 0);

      // SUB to zero
      host_write(5'd1, 32'h1234);
      host_write(5'd2, 32'h1234);
      run_op(5'd1, 5'd2, 5'd4, 6'h22, 1'b0, 1'b0);
      peek("sub_r4", 5'd4, 32'd0);
      check("sub_zero", zero, 1);

      // SLT, NOR, AND, OR
      host_write(5'd1, 32'hFFFFFFFF);
      host_write(5'd2, 32'd1);
      run_op(5'd1, 5'd2, 5'd5, 6'h2A, 1'b0, 1'b0);
      peek("slt_r5", 5'd5, 32'd1);
      run_op(5'd0, 5'd0, 5'd6, 6'h27, 1'b0, 1'b0);
      peek("nor_r6", 5'd6, 32'hFFFFFFFF);
      run_op(5'd1, 5'd2, 5'd7, 6'h24, 1'b0, 1'b0);
      run_op(5'd1, 5'd2, 5'd8, 6'h25, 1'b0, 1'b0);

      // illegal functs, then ADD to r0
      run_illegal(5'd1, 5'd2, 5'd9, 6'h00);
      run_illegal(5'd1, 5'd2, 5'd5, 6'h21);
      peek("ill_r5_kept", 5'd5, 32'd1);
      run_op(5'd1, 5'd2, 5'd0, 6'h20, 1'b0, 1'b0);

      // host write conflicts with write-back; instr_valid held while busy
      host_write(5'd1, 32'd5);
      host_write(5'd2, 32'd7);
      run_op(5'd1, 5'd2, 5'd3, 6'h20, 1'b1, 1'b1);
      peek("conflict_r3", 5'd3, 32'd12);

      // reset during EXEC
      @(negedge clk);
      instr = {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_x", X, 32'd5);
      rst_n = 1'b0;
      rd_addr = 5'd1;
      #1;
      check("midrst_x", X, 0);
      check("midrst_r1", rd_data, 0);
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      sb.delete();
      zc_exp = 0; last_x = '0; last_y = '0; last_s = '0;
      repeat (2) begin
         @(negedge clk);
         check("midrst_done", done, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("release_ready", instr_ready, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("no_done_after_rst", done, 0);
      end
      peek("rst_r7", 5'd7, 32'd0);
      peek("rst_r3", 5'd3, 32'd0);
`ifdef ALU_ISSUER_ZCOUNT_EN
      check("rst_zcount", zcount, 0);
`endif

      // resume after reset
      host_write(5'd1, 32'd3);
      host_write(5'd2, 32'd4);
      run_op(5'd1, 5'd2, 5'd3, 6'h20, 1'b0, 1'b0);
      peek("resume_r3", 5'd3, 32'd7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 SHALL provide parameter NREG, default 32, giving the register-file depth; the address width is 5 bits and NREG is fixed at 32.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port instr_valid, input, 1, instruction word offered.
REQ-005 SHALL provide port instr_ready, output, 1, issuer able to accept an instruction.
REQ-006 SHALL provide port instr, input, 32, MIPS R-type word: [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct.
REQ-007 SHALL provide ports X and Y, output, 32 each, ALU operands.
REQ-008 SHALL provide port S, output, 4, ALU operation code.
REQ-009 SHALL provide port r, input, 32, ALU result, combinational from X/Y/S.
REQ-010 SHALL provide port Zflag, input, 1, ALU zero flag.
REQ-011 SHALL provide ports wr_en (input, 1), wr_addr (input, 5) and wr_data (input, 32), the host register-preload port.
REQ-012 SHALL provide ports rd_addr (input, 5) and rd_data (output, 32), the combinational debug read port.
REQ-013 SHALL provide ports done (output, 1), illegal (output, 1) and zero (output, 1): completion pulse, illegal-funct pulse, and the Zflag captured for the completed instruction.

Function
REQ-014 SHALL implement FSM states IDLE, DECODE, EXEC and WB; the only transitions are IDLE->DECODE, DECODE->EXEC, DECODE->IDLE, EXEC->WB and WB->IDLE.
REQ-015 SHALL assert instr_ready only in IDLE; an instruction is accepted when instr_valid and instr_ready are both high at a clock edge, latching instr and moving to DECODE.
REQ-016 SHALL decode funct in DECODE as 0x24->S=0, 0x25->S=1, 0x20->S=2, 0x22->S=6, 0x2A->S=7, 0x27->S=12, and register X=reg[rs], Y=reg[rt] and S at the DECODE->EXEC edge.
REQ-017 SHALL, for any other funct, pulse illegal for one cycle, leave X/Y/S and all registers unchanged, and return to IDLE.
REQ-018 SHALL hold X/Y/S stable through EXEC and WB, sample r and Zflag at the EXEC->WB edge, and write the result to reg[rd] at the WB->IDLE edge unless rd==0.
REQ-019 SHALL assert done for one cycle and drive zero with the sampled Zflag, coincident with the first IDLE cycle after WB; zero holds until the next done.
REQ-020 SHALL, with acceptance at edge N, raise done in the cycle after edge N+3, giving a throughput of one instruction per 4 cycles.
REQ-021 SHALL hardwire reg[0] to read 0, ignoring writes to it from any source.
REQ-022 SHALL honour a host write in every state; on a same-edge conflict with a WB write to the same address, the WB write wins.
REQ-023 SHALL sample rs/rt contents at the DECODE->EXEC edge, so a host write to rs/rt landing at that edge or later does not affect the in-flight instruction.
REQ-024 SHALL drive rd_data = reg[rd_addr] combinationally, showing a write from the cycle after the write edge.

Reset
REQ-025 SHALL on rst_n low immediately force state IDLE; X=0, Y=0, S=0; done=0, illegal=0, zero=0; all registers 0.
REQ-026 SHALL drop an instruction in flight when reset is asserted mid-operation, with no write-back and no done.
REQ-027 SHALL drive instr_ready high from the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, with ALU_ISSUER_ZCOUNT_EN defined, add output zcount (16 bits), reset to 0, which increments on each done with zero=1, saturates at 0xFFFF, and does not count illegal instructions.
REQ-029 SHALL, without ALU_ISSUER_ZCOUNT_EN, have no zcount port and no counter logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover ADD: preload r1=5, r2=7; issue ADD rd=3 rs=1 rt=2 -> X=5, Y=7, S=2 in EXEC; done after 4 cycles; rd_data(3)=12; zero=0.
REQ-031 SHALL cover SUB to zero: r1=r2=0x1234; issue SUB rd=4 -> S=6; reg4=0; zero=1; zcount=1 when ALU_ISSUER_ZCOUNT_EN is defined.
REQ-032 SHALL cover SLT and NOR: r1=0xFFFFFFFF, r2=1; SLT rd=5 -> reg5=1, S=7; NOR rd=6 rs=0 rt=0 -> S=12, reg6=0xFFFFFFFF.
REQ-033 SHALL cover an illegal funct and rd=0: funct=0x00 -> illegal pulse, no done, registers unchanged, instr_ready back after 2 cycles; ADD rd=0 -> done=1, rd_data(0)=0.
REQ-034 SHALL cover a host-write conflict: host writes reg3=0xAAAA at the same edge WB writes reg3=12 -> reg3=12; instr_valid held high while busy -> no second accept before IDLE.
REQ-035 SHALL cover reset mid-operation: rst_n low during EXEC -> done never pulses; all registers 0; instr_ready=1 on release.
